fir_shift_add_pipe: RTL and testbench

Parametrised multiplierless FIR filter. Each tap coefficient is a power-of-two right shift, and tap terms are summed with optionally approximate prefix adders. It has a two-stage registered adder pipeline, valid/ready handshakes on input and output, synchronous clear, and an output that saturates at full scale. It sits in the same filter datapath as the existing 5-tap shift-add FIR and is a drop-in generalisation of it for the adder-approximation experiments.

---
 rtl/fir_shift_add_pipe_if.sv | 22 ++
 rtl/fir_shift_add_pipe.sv | 99 +++++++++
 tb/tb_fir_shift_add_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_shift_add_pipe_if.sv
// Sample-in / result-out handshake bundle for fir_shift_add_pipe.
// The filter takes the slave view; the producer/consumer side takes the master view.
interface fir_shift_add_pipe_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fir_shift_add_pipe.sv
// Multiplierless shift-add FIR with a two-stage registered adder tree and a saturating output.
// Define FIR_APPROX_EN to make every tree adder approximate in its low APPROX_K bits.
module fir_shift_add_pipe #(
    parameter int                WIDTH    = 16,
    parameter int                TAPS     = 5,
    parameter logic [TAPS*4-1:0] SHIFTS   = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5},
    parameter int                APPROX_K = 2
) (
    input logic               clk,
    input logic               rst,
    input logic               clr,
    fir_shift_add_pipe_if.slave bus
);
    localparam int IW = WIDTH + 4;
    localparam int H  = (TAPS + 1) / 2;

    if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
        $error("fir_shift_add_pipe: TAPS out of range");
    end
    if (APPROX_K < 1 || APPROX_K > WIDTH - 1) begin : g_bad_k
        $error("fir_shift_add_pipe: APPROX_K out of range");
    end

    function automatic logic [IW-1:0] add_a(input logic [IW-1:0] a, input logic [IW-1:0] b);
`ifdef FIR_APPROX_EN
        logic [IW-1:0] r;
        // Low bits are a carry-free XOR; only the top low bit pair feeds a carry upward.
        r[APPROX_K-1:0]  = a[APPROX_K-1:0] ^ b[APPROX_K-1:0];
        r[IW-1:APPROX_K] = a[IW-1:APPROX_K] + b[IW-1:APPROX_K]
                         + (IW-APPROX_K)'(a[APPROX_K-1] & b[APPROX_K-1]);
        return r;
`else
        return a + b;
`endif
    endfunction

    logic [WIDTH-1:0] dly [TAPS-1];
    logic [IW-1:0]    term [TAPS];
    logic [IW-1:0]    sum_a, sum_b, pa, pb, y;
    logic             v1, out_valid_r, load2, accept;
    logic [WIDTH-1:0] out_data_r;

    // Tap 0 is the sample on the input this cycle; the register line holds the older ones.
    assign term[0] = {4'b0000, bus.in_data >> SHIFTS[3:0]};
    for (genvar g = 1; g < TAPS; g++) begin : g_term
        assign term[g] = {4'b0000, dly[g-1] >> SHIFTS[g*4 +: 4]};
    end

    always_comb begin
        sum_a = term[0];
        sum_b = term[H];
        for (int i = 1; i < TAPS; i++) begin
            if (i < H)
                sum_a = add_a(sum_a, term[i]);
            else if (i > H)
                sum_b = add_a(sum_b, term[i]);
        end
    end

    assign y        = add_a(pa, pb);
    assign load2    = !out_valid_r || bus.out_ready;
    assign bus.in_ready = !clr && (!v1 || load2);
    assign accept   = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS-1; i++) dly[i] <= '0;
            pa          <= '0;
            pb          <= '0;
            v1          <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (clr) begin
            for (int i = 0; i < TAPS-1; i++) dly[i] <= '0;
            pa          <= '0;
            pb          <= '0;
            v1          <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (accept) begin
                dly[0] <= bus.in_data;
                for (int i = 1; i < TAPS-1; i++) dly[i] <= dly[i-1];
                pa <= sum_a;
                pb <= sum_b;
            end
            if (!v1 || load2)
                v1 <= accept;
            if (load2) begin
                out_valid_r <= v1;
                if (v1)
                    out_data_r <= (|y[IW-1:WIDTH]) ? {WIDTH{1'b1}} : y[WIDTH-1:0];
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_fir_shift_add_pipe.sv
// Scoreboard bench for fir_shift_add_pipe: default 5-tap instance plus a 2-tap zero-shift instance for saturation.
module tb_fir_shift_add_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    fir_shift_add_pipe_if #(.WIDTH(16)) bi ();
    fir_shift_add_pipe_if #(.WIDTH(16)) si ();

    fir_shift_add_pipe dut (.clk(clk), .rst(rst), .clr(clr), .bus(bi));
    fir_shift_add_pipe #(.WIDTH(16), .TAPS(2), .SHIFTS(8'h00)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .bus(si));

    typedef struct {
        logic [15:0] data;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [15:0] imp_in  [6] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] imp_exp [6] = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000};
`ifdef FIR_APPROX_EN
    logic [15:0] const_exp [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0009, 16'h0016};
`else
    logic [15:0] const_exp [5] = '{16'h0000, 16'h0001, 16'h0004, 16'h000B, 16'h001A};
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic mon(input bit sel);
        exp_t        e;
        logic [15:0] d;
        int          n;
        d = sel ? si.out_data : bi.out_data;
        n = sel ? q1.size() : q0.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out[%0d]: got %h expected no output", sel, d);
        end else begin
            if (sel) e = q1.pop_front();
            else     e = q0.pop_front();
            check($sformatf("out_data[%0d]", sel), 32'(d), 32'(e.data));
            if (e.lat)
                check($sformatf("latency[%0d]", sel), cyc - e.acc, 2);
        end
    endtask

    always @(negedge clk) if (rst && bi.out_valid && bi.out_ready) mon(1'b0);
    always @(negedge clk) if (rst && si.out_valid && si.out_ready) mon(1'b1);

    // Offers a sample and holds it until accepted; leaves in_valid high so calls stream back to back.
    task automatic send(input bit sel, input logic [15:0] d, input logic [15:0] expv,
                        input bit lat, input bit push);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        if (sel) begin si.in_data = d; si.in_valid = 1'b1; end
        else     begin bi.in_data = d; bi.in_valid = 1'b1; end
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = sel ? si.in_ready : bi.in_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%0d]: in_ready 0 expected 1", sel);
        end else if (push) begin
            e.data = expv;
            e.acc  = cyc;
            e.lat  = lat;
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bi.in_valid = 1'b0;
        si.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
        #1;
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bi.in_data = '0; bi.in_valid = 1'b0; bi.out_ready = 1'b1;
        si.in_data = '0; si.in_valid = 1'b0; si.out_ready = 1'b1;
        #12;
        check("rst_out_valid", bi.out_valid, 0);
        check("rst_out_data", bi.out_data, 0);
        check("rst_in_ready", bi.in_ready, 1);
        check("rst_sat_in_ready", si.in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // impulse, streaming one sample per cycle
        foreach (imp_in[i]) send(1'b0, imp_in[i], imp_exp[i], 1'b1, 1'b1);
        idle();
        drain();

        // constant 0x001F
        foreach (const_exp[i]) send(1'b0, 16'h001F, const_exp[i], 1'b1, 1'b1);
        idle();
        drain();
        do_clr();

        // backpressure: two accepts fill the pipe, third sample waits
        bi.out_ready = 1'b0;
        send(1'b0, 16'h0100, 16'h0008, 1'b0, 1'b1);
        send(1'b0, 16'h0200, 16'h0020, 1'b0, 1'b1);
        bi.in_data  = 16'h0400;
        bi.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", bi.in_ready, 0);
            check("bp_out_valid", bi.out_valid, 1);
            check("bp_out_data", bi.out_data, 16'h0008);
        end
        @(posedge clk);
        #1;
        bi.out_ready = 1'b1;
        send(1'b0, 16'h0400, 16'h0060, 1'b0, 1'b1);
        idle();
        drain();
        do_clr();

        // clear with two results in flight
        send(1'b0, 16'h1000, 16'h0080, 1'b1, 1'b1);
        send(1'b0, 16'h2000, 16'h0000, 1'b0, 1'b0);
        send(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0);
        idle();
        clr = 1'b1;
        bi.out_ready = 1'b0;
        @(negedge clk);
        check("clr_in_ready", bi.in_ready, 0);
        @(posedge clk);
        #1;
        check("clr_out_valid", bi.out_valid, 0);
        clr = 1'b0;
        bi.out_ready = 1'b1;
        send(1'b0, 16'h8000, 16'h0400, 1'b1, 1'b1);
        send(1'b0, 16'h0000, 16'h0800, 1'b1, 1'b1);
        idle();
        drain();

        // saturation on the 2-tap zero-shift instance
        send(1'b1, 16'hC000, 16'hC000, 1'b1, 1'b1);
        send(1'b1, 16'hC000, 16'hFFFF, 1'b1, 1'b1);
        idle();
        drain();
        do_clr();
        send(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b1);
        send(1'b1, 16'h4000, 16'h8000, 1'b1, 1'b1);
        idle();
        drain();

        // asynchronous reset while results are stalled
        bi.out_ready = 1'b0;
        send(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0);
        send(1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("pre_rst_out_valid", bi.out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", bi.out_valid, 0);
        check("async_rst_out_data", bi.out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", bi.in_ready, 1);
        bi.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 16'h8000, 16'h0400, 1'b1, 1'b1);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
